// File: rtl/ibex_cap_lsu_pkg.sv
// rtl/ibex_cap_lsu_pkg.sv - capability LSU types, sizes and beat pack/unpack helpers
// A capability is moved as CAP_BEATS little-endian 32-bit words, the top word zero-padded.
package ibex_cap_lsu_pkg;

  localparam int unsigned CAP_SIZE  = 93;
  localparam int unsigned CAP_BEATS = 3;
  localparam int unsigned CAP_PAD_W = 32 * CAP_BEATS;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DONE,
    ERR
  } cap_lsu_state_e;

  function automatic logic [31:0] cap_to_word(input logic [CAP_SIZE-1:0] cap,
                                              input logic [1:0]          beat);
    logic [CAP_PAD_W-1:0] padded;
    padded = {{(CAP_PAD_W - CAP_SIZE){1'b0}}, cap};
    case (beat)
      2'd0:    return padded[31:0];
      2'd1:    return padded[63:32];
      default: return padded[95:64];
    endcase
  endfunction

  // Bits above CAP_SIZE in the last word are dropped on reassembly.
  function automatic logic [CAP_SIZE-1:0] word_to_cap(input logic [CAP_PAD_W-1:0] words);
    return words[CAP_SIZE-1:0];
  endfunction

endpackage

// File: rtl/ibex_cap_lsu.sv
// rtl/ibex_cap_lsu.sv - capability load/store sequencer moving a capability as 3 bus word beats
// Optional CAP_LSU_PIPELINE_EN: up to two outstanding beats with in-order responses.
module ibex_cap_lsu
  import ibex_cap_lsu_pkg::*;
#(
  parameter int unsigned CAP_W       = CAP_SIZE,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cap_req_i,
  input  logic             cap_we_i,
  input  logic [31:0]      cap_addr_i,
  input  logic [CAP_W-1:0] cap_wdata_i,
  output logic             busy_o,
  output logic             cap_valid_o,
  output logic [CAP_W-1:0] cap_rdata_o,
  output logic             cap_err_o,
  output logic             cap_misalign_o,
  output logic             data_req_o,
  input  logic             data_gnt_i,
  input  logic             data_rvalid_i,
  input  logic             data_err_i,
  output logic [31:0]      data_addr_o,
  output logic             data_we_o,
  output logic [3:0]       data_be_o,
  output logic [31:0]      data_wdata_o,
  input  logic [31:0]      data_rdata_i
);

  cap_lsu_state_e   state_q;
  logic [1:0]       beat_q;
  logic             we_q;
  logic [31:0]      addr_q;
  logic [CAP_W-1:0] wdata_q;
  logic [31:0]      slot_q [CAP_BEATS];
  logic             req_q;
  logic             valid_q;
  logic             err_q;
  logic             misalign_q;
  logic             misaligned;

  assign misaligned = ALIGN_CHECK && (cap_addr_i[3:0] != 4'h0);

`ifdef CAP_LSU_PIPELINE_EN
  logic [1:0] rsp_q;
  logic [1:0] out_q;
  logic       drain_q;
  logic       gnt_fire;
  logic [1:0] beat_nxt;
  logic [1:0] out_nxt;
  logic       drain_nxt;
  logic       hold_req;
  logic       issue_ok;
  logic       req_nxt;
  logic       finish;

  assign gnt_fire  = req_q & data_gnt_i;
  assign beat_nxt  = beat_q + {1'b0, gnt_fire};
  assign out_nxt   = out_q + {1'b0, gnt_fire} - {1'b0, data_rvalid_i};
  assign drain_nxt = drain_q | (data_rvalid_i & data_err_i);
  // An ungranted request is never retracted, even once an error has been seen.
  assign hold_req  = req_q & ~data_gnt_i;
  assign issue_ok  = ~drain_nxt && (beat_nxt != 2'd3) && (out_nxt != 2'd2);
  assign req_nxt   = hold_req | issue_ok;
  assign finish    = ~hold_req && (out_nxt == 2'd0) && (drain_nxt || (beat_nxt == 2'd3));
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      beat_q     <= 2'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= '0;
      req_q      <= 1'b0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      misalign_q <= 1'b0;
      for (int i = 0; i < CAP_BEATS; i++) slot_q[i] <= 32'h0;
`ifdef CAP_LSU_PIPELINE_EN
      rsp_q      <= 2'd0;
      out_q      <= 2'd0;
      drain_q    <= 1'b0;
`endif
    end else begin
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      misalign_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cap_req_i) begin
            addr_q  <= cap_addr_i;
            we_q    <= cap_we_i;
            wdata_q <= cap_wdata_i;
            beat_q  <= 2'd0;
`ifdef CAP_LSU_PIPELINE_EN
            rsp_q   <= 2'd0;
            out_q   <= 2'd0;
            drain_q <= 1'b0;
`endif
            if (misaligned) begin
              state_q    <= ERR;
              valid_q    <= 1'b1;
              err_q      <= 1'b1;
              misalign_q <= 1'b1;
            end else begin
              state_q <= REQ;
              req_q   <= 1'b1;
            end
          end
        end
`ifdef CAP_LSU_PIPELINE_EN
        REQ, WAIT: begin
          if (data_rvalid_i) begin
            if (!we_q) slot_q[rsp_q] <= data_rdata_i;
            rsp_q <= rsp_q + 2'd1;
          end
          beat_q  <= beat_nxt;
          out_q   <= out_nxt;
          drain_q <= drain_nxt;
          req_q   <= req_nxt & ~finish;
          if (finish) begin
            state_q <= drain_nxt ? ERR : DONE;
            valid_q <= 1'b1;
            err_q   <= drain_nxt;
          end else begin
            state_q <= req_nxt ? REQ : WAIT;
          end
        end
`else
        REQ: begin
          if (data_gnt_i) begin
            req_q   <= 1'b0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (data_rvalid_i) begin
            if (!we_q) slot_q[beat_q] <= data_rdata_i;
            if (data_err_i) begin
              state_q <= ERR;
              valid_q <= 1'b1;
              err_q   <= 1'b1;
            end else if (beat_q == 2'd2) begin
              state_q <= DONE;
              valid_q <= 1'b1;
            end else begin
              beat_q  <= beat_q + 2'd1;
              req_q   <= 1'b1;
              state_q <= REQ;
            end
          end
        end
`endif
        DONE, ERR: state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

  assign busy_o         = (state_q != IDLE);
  assign cap_valid_o    = valid_q;
  assign cap_err_o      = err_q;
  assign cap_misalign_o = misalign_q;
  assign cap_rdata_o    = (valid_q && !err_q && !we_q) ?
                          word_to_cap({slot_q[2], slot_q[1], slot_q[0]}) : '0;

  assign data_req_o   = req_q;
  assign data_we_o    = req_q & we_q;
  assign data_be_o    = {4{req_q}};
  assign data_addr_o  = req_q ? (addr_q + {28'h0, beat_q, 2'b00}) : 32'h0;
  assign data_wdata_o = (req_q && we_q) ? cap_to_word(wdata_q, beat_q) : 32'h0;

`ifndef CAP_LSU_PIPELINE_EN
  a_rvalid_not_idle_req: assert property (@(posedge clk_i) disable iff (!rst_ni)
    data_rvalid_i |-> !(state_q inside {IDLE, REQ}));
`else
  a_rvalid_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
    data_rvalid_i |-> (out_q != 2'd0) || gnt_fire);
`endif
  a_req_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (data_req_o && !data_gnt_i) |=> data_req_o && $stable(data_addr_o) &&
                                    $stable(data_we_o) && $stable(data_wdata_o));

endmodule

// File: tb/tb_ibex_cap_lsu.sv
// tb/tb_ibex_cap_lsu.sv - self-checking bench for ibex_cap_lsu (default build)
module tb_ibex_cap_lsu;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        cap_req_i = 1'b0;
  logic        cap_we_i = 1'b0;
  logic [31:0] cap_addr_i = 32'h0;
  logic [92:0] cap_wdata_i = '0;
  logic        busy_o, cap_valid_o, cap_err_o, cap_misalign_o;
  logic [92:0] cap_rdata_o;
  logic        data_req_o, data_we_o;
  logic        data_gnt_i = 1'b0, data_rvalid_i = 1'b0, data_err_i = 1'b0;
  logic [31:0] data_addr_o, data_wdata_o;
  logic [31:0] data_rdata_i = 32'h0;
  logic [3:0]  data_be_o;

  ibex_cap_lsu dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cap_req_i(cap_req_i), .cap_we_i(cap_we_i),
    .cap_addr_i(cap_addr_i), .cap_wdata_i(cap_wdata_i), .busy_o(busy_o),
    .cap_valid_o(cap_valid_o), .cap_rdata_o(cap_rdata_o), .cap_err_o(cap_err_o),
    .cap_misalign_o(cap_misalign_o), .data_req_o(data_req_o), .data_gnt_i(data_gnt_i),
    .data_rvalid_i(data_rvalid_i), .data_err_i(data_err_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rdata_i(data_rdata_i)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } beat_t;

  // Model of the transaction in flight.
  beat_t       exp_q[$];
  int          start_cyc = -10;
  int          valid_cyc = -10;
  logic        exp_we = 1'b0, exp_err = 1'b0, exp_mis = 1'b0;
  logic [92:0] exp_rdata = '0;

  // Bus responder configuration and log.
  int          gnt_delay = 0;
  int          err_beat = -1;
  logic [31:0] rd_words [3];
  int          rsp_idx = 0;
  bit          pend = 1'b0;
  int          wcnt = 0;
  logic [31:0] log_addr[$];
  logic [31:0] log_wdata[$];

  // Observations recorded by the compare process.
  int          last_rel = -1;
  logic [92:0] last_rdata = '0;
  logic        last_err = 1'b0, last_mis = 1'b0;

  always @(negedge clk_i) begin
    data_gnt_i    = 1'b0;
    data_rvalid_i = 1'b0;
    data_err_i    = 1'b0;
    data_rdata_i  = 32'h0;
    if (!rst_ni) begin
      pend = 1'b0;
      wcnt = 0;
    end else begin
      if (pend) begin
        data_rvalid_i = 1'b1;
        data_rdata_i  = (rsp_idx < 3) ? rd_words[rsp_idx] : 32'hDEAD_BEEF;
        data_err_i    = (rsp_idx == err_beat);
        rsp_idx++;
        pend = 1'b0;
      end
      if (data_req_o) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_req", {data_req_o, data_addr_o}, {1'b0, data_addr_o});
        end else begin
          chk("beat_addr", data_addr_o, exp_q[0].addr);
          chk("beat_we", data_we_o, exp_q[0].we);
          chk("beat_be", data_be_o, 4'hF);
          if (exp_q[0].we) chk("beat_wdata", data_wdata_o, exp_q[0].wdata);
        end
        if (wcnt >= gnt_delay) begin
          data_gnt_i = 1'b1;
          pend = 1'b1;
          wcnt = 0;
          log_addr.push_back(data_addr_o);
          log_wdata.push_back(data_wdata_o);
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
          wcnt++;
        end
      end
    end
  end

  always @(posedge clk_i) begin
    #2;
    if (rst_ni) begin
      chk("busy", busy_o, (cyc > start_cyc) && (cyc <= valid_cyc));
      chk("valid", cap_valid_o, cyc == valid_cyc);
      chk("err", cap_err_o, (cyc == valid_cyc) && exp_err);
      chk("misalign", cap_misalign_o, (cyc == valid_cyc) && exp_mis);
      if (cap_valid_o) begin
        last_rel   = cyc - start_cyc;
        last_rdata = cap_rdata_o;
        last_err   = cap_err_o;
        last_mis   = cap_misalign_o;
        if (!exp_we || exp_err) chk("rdata", cap_rdata_o, exp_rdata);
      end
    end
  end

  task automatic launch(input logic we, input logic [31:0] addr, input logic [92:0] cap,
                        input int gd, input int eb,
                        input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    logic [95:0] pad;
    int nb;
    @(negedge clk_i);
    gnt_delay   = gd;
    err_beat    = eb;
    rd_words[0] = w0;
    rd_words[1] = w1;
    rd_words[2] = w2;
    rsp_idx     = 0;
    last_rel    = -1;
    exp_we      = we;
    exp_mis     = (addr[3:0] != 4'h0);
    exp_err     = exp_mis || (eb >= 0);
    exp_rdata   = exp_err ? 93'h0 : {w2[28:0], w1, w0};
    pad         = {3'b000, cap};
    nb          = exp_mis ? 0 : ((eb >= 0) ? eb + 1 : 3);
    exp_q.delete();
    for (int b = 0; b < nb; b++) exp_q.push_back('{addr + 32'(4 * b), we, pad[32*b +: 32]});
    start_cyc   = cyc;
    valid_cyc   = exp_mis ? cyc + 1 : cyc + 1 + nb * (2 + gd);
    cap_req_i   = 1'b1;
    cap_we_i    = we;
    cap_addr_i  = addr;
    cap_wdata_i = cap;
    @(negedge clk_i);
    cap_req_i   = 1'b0;
  endtask

  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [92:0] cap,
                         input int gd, input int eb,
                         input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2);
    launch(we, addr, cap, gd, eb, w0, w1, w2);
    while (cyc <= valid_cyc + 1) @(negedge clk_i);
    chk("beats_left", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [92:0] cap1, cap5;
    int s;
    cap1 = {29'h0001_2345, 32'hABCD_EF01, 32'h2345_6789};
    cap5 = {29'h1555_AAAA, 32'hCAFE_F00D, 32'h0BAD_BEEF};
    repeat (2) @(negedge clk_i);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_valid", cap_valid_o, 1'b0);
    chk("rst_err", {cap_err_o, cap_misalign_o}, 2'b00);
    chk("rst_req", {data_req_o, data_we_o, data_be_o}, 6'h0);
    chk("rst_bus", {data_addr_o, data_wdata_o}, 64'h0);
    chk("rst_rdata", cap_rdata_o, 93'h0);
    rst_ni = 1'b1;

    log_addr.delete(); log_wdata.delete();
    run_txn(1'b1, 32'h1000, cap1, 0, -1, 32'h0, 32'h0, 32'h0);
    chk("t1_latency", last_rel, 7);
    chk("t1_w0", log_wdata[0], 32'h2345_6789);
    chk("t1_w1", log_wdata[1], 32'hABCD_EF01);
    chk("t1_w2", log_wdata[2], 32'h0001_2345);
    chk("t1_a2", log_addr[2], 32'h1008);

    run_txn(1'b0, 32'h2000, '0, 0, -1, 32'h1111_1111, 32'h2222_2222, 32'hFFFF_FFFF);
    chk("t2_rdata", last_rdata, {29'h1FFF_FFFF, 32'h2222_2222, 32'h1111_1111});

    log_addr.delete();
    run_txn(1'b0, 32'h2004, '0, 0, -1, 32'h0, 32'h0, 32'h0);
    chk("t3_latency", last_rel, 1);
    chk("t3_flags", {last_err, last_mis}, 2'b11);
    chk("t3_no_bus", log_addr.size(), 0);

    log_addr.delete();
    run_txn(1'b0, 32'h2400, '0, 0, 1, 32'h5555_5555, 32'h6666_6666, 32'h7777_7777);
    chk("t4_err", {last_err, last_mis}, 2'b10);
    chk("t4_rdata", last_rdata, 93'h0);
    chk("t4_beats", log_addr.size(), 2);

    run_txn(1'b1, 32'h3000, cap5, 3, -1, 32'h0, 32'h0, 32'h0);
    chk("t5_latency", last_rel, 16);
    run_txn(1'b0, 32'h3010, '0, 3, -1, 32'h8765_4321, 32'h0F0F_0F0F, 32'hE000_0001);
    chk("t5_rdata", last_rdata, {29'h0000_0001, 32'h0F0F_0F0F, 32'h8765_4321});

    launch(1'b0, 32'h4000, '0, 0, -1, 32'h1, 32'h2, 32'h3);
    s = start_cyc;
    while (cyc < s + 4) @(negedge clk_i);
    #1 rst_ni = 1'b0;
    start_cyc = -10;
    valid_cyc = -10;
    exp_q.delete();
    #1;
    chk("t6_req_dropped", data_req_o, 1'b0);
    chk("t6_busy_dropped", busy_o, 1'b0);
    @(negedge clk_i);
    chk("t6_no_valid", cap_valid_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    log_addr.delete();
    run_txn(1'b0, 32'hFFFF_FFF0, '0, 1, -1, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h0000_0007);
    chk("t6_latency", last_rel, 10);
    chk("t6_rdata", last_rdata, {29'h0000_0007, 32'h5A5A_5A5A, 32'hA5A5_A5A5});
    chk("t6_top_addr", log_addr[2], 32'hFFFF_FFF8);
    run_txn(1'b1, 32'hFFFF_FFF0, cap5, 0, 2, 32'h0, 32'h0, 32'h0);
    chk("t6_store_err", {last_err, last_mis}, 2'b10);

    repeat (2) @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
